// File: rtl/mips32_pkg.sv
// Shared definitions for the mips32 five-stage core: opcodes, instruction classes, ALU ops.
// Optional MUL support is controlled by the MIPS32_MUL_EN macro.
package mips32_pkg;

  localparam int unsigned MEM_DEPTH_DEFAULT = 1024;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP
  } iclass_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  } aluop_t;

  function automatic iclass_t op_class(input logic [5:0] opc);
    iclass_t c;
    c = NOP;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT: c = RR_ALU;
`ifdef MIPS32_MUL_EN
      OP_MUL:                                c = RR_ALU;
`endif
      OP_ADDI, OP_SUBI, OP_SLTI:             c = RM_ALU;
      OP_LW:                                 c = LOAD;
      OP_SW:                                 c = STORE;
      OP_BNEQZ, OP_BEQZ:                     c = BRANCH;
      OP_HLT:                                c = HALT;
      default:                               c = NOP;
    endcase
    return c;
  endfunction

  function automatic aluop_t op_alu(input logic [5:0] opc);
    aluop_t a;
    a = ALU_ADD;
    case (opc)
      OP_SUB, OP_SUBI: a = ALU_SUB;
      OP_AND:          a = ALU_AND;
      OP_OR:           a = ALU_OR;
      OP_SLT, OP_SLTI: a = ALU_SLT;
      OP_MUL:          a = ALU_MUL;
      default:         a = ALU_ADD;
    endcase
    return a;
  endfunction

  function automatic logic writes_reg(input iclass_t c);
    return (c == RR_ALU) || (c == RM_ALU) || (c == LOAD);
  endfunction

endpackage

// File: rtl/mips32_if.sv
// Commit/status bus of the mips32 core: register-file writes, memory writes, branch pulse.
interface mips32_if;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        dm_we;
  logic [31:0] dm_waddr;
  logic [31:0] dm_wdata;
  logic        taken_branch;

  modport master (
    output rf_we, rf_waddr, rf_wdata, dm_we, dm_waddr, dm_wdata, taken_branch
  );
  modport slave (
    input  rf_we, rf_waddr, rf_wdata, dm_we, dm_waddr, dm_wdata, taken_branch
  );
endinterface

// File: rtl/mips32_alu.sv
// Combinational ALU of the mips32 core; MUL exists only when MIPS32_MUL_EN is defined.
module mips32_alu
  import mips32_pkg::*;
(
  input  aluop_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {31'b0, ($signed(a) < $signed(b))};
`ifdef MIPS32_MUL_EN
      ALU_MUL: y = a * b;
`endif
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/mips32_core.sv
// Five-stage in-order MIPS32-subset core with unified word-addressed memory.
// MUL support follows MIPS32_MUL_EN (see mips32_pkg / mips32_alu).
module mips32_core
  import mips32_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
)(
  input  logic     clk,
  input  logic     rst_n,
  output logic     halted,
  mips32_if.master cmt
);
  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [31:0]   mem     [MEM_DEPTH];
  logic [31:0]   regfile [32];
  logic [AW-1:0] pc;
  logic          taken_branch;

  logic          if_id_valid;
  logic [31:0]   if_id_ir;
  logic [31:0]   if_id_npc;

  iclass_t       id_ex_cls;
  aluop_t        id_ex_op;
  logic          id_ex_beqz;
  logic [4:0]    id_ex_rs, id_ex_rt, id_ex_dest;
  logic [31:0]   id_ex_a, id_ex_b, id_ex_imm, id_ex_npc;

  iclass_t       ex_mem_cls;
  logic [4:0]    ex_mem_dest;
  logic [31:0]   ex_mem_alu, ex_mem_b;

  iclass_t       mem_wb_cls;
  logic [4:0]    mem_wb_dest;
  logic [31:0]   mem_wb_res;

  // ID
  logic [5:0]  id_opc;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_imm, id_a, id_b;
  iclass_t     id_cls;
  logic        wb_we, halt_wb;

  assign id_opc  = if_id_ir[31:26];
  assign id_rs   = if_id_ir[25:21];
  assign id_rt   = if_id_ir[20:16];
  assign id_rd   = if_id_ir[15:11];
  assign id_imm  = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
  assign id_cls  = if_id_valid ? op_class(id_opc) : NOP;
  assign wb_we   = writes_reg(mem_wb_cls) && (mem_wb_dest != '0);
  assign halt_wb = (mem_wb_cls == HALT);

  // r0 is never written, so regfile[0] stays zero without a read-side mask
  always_comb begin
    id_a = regfile[id_rs];
    id_b = regfile[id_rt];
    if (wb_we && mem_wb_dest == id_rs) id_a = mem_wb_res;
    if (wb_we && mem_wb_dest == id_rt) id_b = mem_wb_res;
  end

  // EX: a load in EX/MEM only has its address, so it is not a forwarding source yet
  logic        fwd_em, ex_taken;
  logic [31:0] ex_a, ex_b, alu_b, ex_y;

  assign fwd_em = ((ex_mem_cls == RR_ALU) || (ex_mem_cls == RM_ALU)) && (ex_mem_dest != '0);

  always_comb begin
    ex_a = id_ex_a;
    ex_b = id_ex_b;
    if (fwd_em && ex_mem_dest == id_ex_rs)      ex_a = ex_mem_alu;
    else if (wb_we && mem_wb_dest == id_ex_rs)  ex_a = mem_wb_res;
    if (fwd_em && ex_mem_dest == id_ex_rt)      ex_b = ex_mem_alu;
    else if (wb_we && mem_wb_dest == id_ex_rt)  ex_b = mem_wb_res;
  end

  assign alu_b    = (id_ex_cls == RR_ALU) ? ex_b : id_ex_imm;
  assign ex_taken = (id_ex_cls == BRANCH) && (id_ex_beqz == (ex_a == '0));

  mips32_alu u_alu (
    .op (id_ex_op),
    .a  (ex_a),
    .b  (alu_b),
    .y  (ex_y)
  );

  // MEM
  logic [31:0] mem_rdata, mem_res;
  assign mem_rdata = mem[ex_mem_alu[AW-1:0]];
  assign mem_res   = (ex_mem_cls == LOAD) ? mem_rdata : ex_mem_alu;

  always_ff @(posedge clk) begin
    if (ex_mem_cls == STORE && !halt_wb)
      mem[ex_mem_alu[AW-1:0]] <= ex_mem_b;
  end

  // HLT in WB freezes every stage, which also blocks younger register/memory effects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) regfile[i] <= '0;
      pc           <= '0;
      halted       <= 1'b0;
      taken_branch <= 1'b0;
      if_id_valid  <= 1'b0;
      if_id_ir     <= '0;
      if_id_npc    <= '0;
      id_ex_cls    <= NOP;
      id_ex_op     <= ALU_ADD;
      id_ex_beqz   <= 1'b0;
      id_ex_rs     <= '0;
      id_ex_rt     <= '0;
      id_ex_dest   <= '0;
      id_ex_a      <= '0;
      id_ex_b      <= '0;
      id_ex_imm    <= '0;
      id_ex_npc    <= '0;
      ex_mem_cls   <= NOP;
      ex_mem_dest  <= '0;
      ex_mem_alu   <= '0;
      ex_mem_b     <= '0;
      mem_wb_cls   <= NOP;
      mem_wb_dest  <= '0;
      mem_wb_res   <= '0;
    end else if (halt_wb) begin
      halted       <= 1'b1;
      taken_branch <= 1'b0;
    end else begin
      if (wb_we) regfile[mem_wb_dest] <= mem_wb_res;
      taken_branch <= ex_taken;

      pc          <= ex_taken ? AW'(id_ex_npc + id_ex_imm) : pc + AW'(1);
      if_id_valid <= !ex_taken;
      if_id_ir    <= mem[pc];
      if_id_npc   <= 32'(pc) + 32'd1;

      id_ex_cls   <= ex_taken ? NOP : id_cls;
      id_ex_op    <= op_alu(id_opc);
      id_ex_beqz  <= (id_opc == OP_BEQZ);
      id_ex_rs    <= id_rs;
      id_ex_rt    <= id_rt;
      id_ex_dest  <= (id_cls == RR_ALU) ? id_rd : id_rt;
      id_ex_a     <= id_a;
      id_ex_b     <= id_b;
      id_ex_imm   <= id_imm;
      id_ex_npc   <= if_id_npc;

      ex_mem_cls  <= id_ex_cls;
      ex_mem_dest <= id_ex_dest;
      ex_mem_alu  <= ex_y;
      ex_mem_b    <= ex_b;

      mem_wb_cls  <= ex_mem_cls;
      mem_wb_dest <= ex_mem_dest;
      mem_wb_res  <= mem_res;
    end
  end

  assign cmt.rf_we        = wb_we;
  assign cmt.rf_waddr     = mem_wb_dest;
  assign cmt.rf_wdata     = mem_wb_res;
  assign cmt.dm_we        = (ex_mem_cls == STORE) && !halt_wb;
  assign cmt.dm_waddr     = ex_mem_alu;
  assign cmt.dm_wdata     = ex_mem_b;
  assign cmt.taken_branch = taken_branch;

endmodule

// File: tb/tb_mips32_core.sv
// Scoreboard bench for mips32_core: expected commits are queued, a monitor checks them.
module tb_mips32_core;
  import mips32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  mips32_if cmt ();

  mips32_core #(.MEM_DEPTH(1024)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .halted (halted),
    .cmt    (cmt)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned taken_cnt = 0;
  logic [36:0] rf_q[$];
  logic [63:0] dm_q[$];
  logic [31:0] prog[$];

  function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic exp_rf(input logic [4:0] r, input logic [31:0] d);
    rf_q.push_back({r, d});
  endtask

  // Monitor: every committed register/memory write must match the next queued expectation
  always @(negedge clk) begin
    logic [36:0] er;
    logic [63:0] ed;
    if (cmt.taken_branch) taken_cnt++;
    if (cmt.rf_we) begin
      checks++;
      if (rf_q.size() == 0) begin
        errors++;
        $display("FAIL rf_commit: got r%0d=%h, required no write", cmt.rf_waddr, cmt.rf_wdata);
      end else begin
        er = rf_q.pop_front();
        if ({cmt.rf_waddr, cmt.rf_wdata} !== er) begin
          errors++;
          $display("FAIL rf_commit: got r%0d=%h, required r%0d=%h",
                   cmt.rf_waddr, cmt.rf_wdata, er[36:32], er[31:0]);
        end
      end
    end
    if (cmt.dm_we) begin
      checks++;
      if (dm_q.size() == 0) begin
        errors++;
        $display("FAIL dm_commit: got mem[%0d]=%h, required no write", cmt.dm_waddr, cmt.dm_wdata);
      end else begin
        ed = dm_q.pop_front();
        if ({cmt.dm_waddr, cmt.dm_wdata} !== ed) begin
          errors++;
          $display("FAIL dm_commit: got mem[%0d]=%h, required mem[%0d]=%h",
                   cmt.dm_waddr, cmt.dm_wdata, ed[63:32], ed[31:0]);
        end
      end
    end
  end

  task automatic wait_halt(input string name);
    int unsigned n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_halted"}, 32'(halted), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_rf_drained"}, rf_q.size(), 32'd0);
    chk({name, "_dm_drained"}, dm_q.size(), 32'd0);
  endtask

  task automatic run(input string name);
    rst_n = 1'b0;
    #3;
    for (int i = 0; i < 1024; i++) dut.mem[i] = '0;
    for (int i = 0; i < prog.size(); i++) dut.mem[i] = prog[i];
    taken_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_halt(name);
  endtask

  initial begin
    logic ok;
    #1;
    chk("reset_pc", 32'(dut.pc), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);

    // Adjacent dependent ALU ops
    prog = '{itype(OP_ADDI, 1, 0, 16'd29), itype(OP_ADDI, 2, 0, 16'd3),
             rtype(OP_ADD, 3, 1, 2), {OP_HLT, 26'b0}};
    exp_rf(1, 29); exp_rf(2, 3); exp_rf(3, 32);
    run("p1");
    chk("p1_r3", dut.regfile[3], 32'd32);
    chk("p1_pc_frozen", 32'(dut.pc), 32'd7);
    chk("p1_taken_cnt", taken_cnt, 32'd0);

    // Async reset after halt, then rerun the resident program
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(dut.pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_taken", 32'(dut.taken_branch), 32'd0);
    chk("rst_wb_bubble", 32'(dut.mem_wb_cls == NOP), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) if (dut.regfile[i] !== '0) ok = 1'b0;
    chk("rst_regfile_zero", 32'(ok), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rf(1, 29); exp_rf(2, 3); exp_rf(3, 32);
    wait_halt("p1b");
    chk("p1b_r3", dut.regfile[3], 32'd32);

    // Shift-by-addition loop
    prog = '{itype(OP_ADDI, 2, 0, 16'd29), itype(OP_ADDI, 4, 0, 16'd0),
             itype(OP_ADDI, 5, 0, 16'd3),  rtype(OP_ADD, 2, 2, 2),
             itype(OP_ADDI, 4, 4, 16'd1),  rtype(OP_SLT, 6, 4, 5),
             itype(OP_BNEQZ, 0, 6, 16'hFFFC), itype(OP_BEQZ, 0, 0, 16'd1),
             itype(OP_ADDI, 7, 0, 16'd1),  {OP_HLT, 26'b0}};
    exp_rf(2, 29); exp_rf(4, 0); exp_rf(5, 3);
    exp_rf(2, 58);  exp_rf(4, 1); exp_rf(6, 1);
    exp_rf(2, 116); exp_rf(4, 2); exp_rf(6, 1);
    exp_rf(2, 232); exp_rf(4, 3); exp_rf(6, 0);
    run("p2");
    chk("p2_r2", dut.regfile[2], 32'd232);
    chk("p2_r4", dut.regfile[4], 32'd3);
    chk("p2_r7_squashed", dut.regfile[7], 32'd0);
    chk("p2_taken_cnt", taken_cnt, 32'd3);

    // Store/load with load-use distance 2
    prog = '{itype(OP_ADDI, 1, 0, 16'd100), itype(OP_ADDI, 2, 0, 16'hFFF9),
             itype(OP_SW, 2, 1, 16'd5), itype(OP_LW, 3, 1, 16'd5),
             {6'b010000, 26'b0}, rtype(OP_ADD, 4, 3, 0), {OP_HLT, 26'b0}};
    exp_rf(1, 100); exp_rf(2, 32'hFFFFFFF9); exp_rf(3, 32'hFFFFFFF9); exp_rf(4, 32'hFFFFFFF9);
    dm_q.push_back({32'd105, 32'hFFFFFFF9});
    run("p3");
    chk("p3_mem105", dut.mem[105], 32'hFFFFFFF9);
    chk("p3_r4", dut.regfile[4], 32'hFFFFFFF9);

    // Taken branch squashes two younger instructions
    prog = '{itype(OP_BEQZ, 0, 0, 16'd2), itype(OP_ADDI, 5, 0, 16'd1),
             itype(OP_ADDI, 6, 0, 16'd1), itype(OP_ADDI, 7, 0, 16'd9), {OP_HLT, 26'b0}};
    exp_rf(7, 9);
    run("p4");
    chk("p4_r5", dut.regfile[5], 32'd0);
    chk("p4_r6", dut.regfile[6], 32'd0);
    chk("p4_r7", dut.regfile[7], 32'd9);
    chk("p4_taken_cnt", taken_cnt, 32'd1);

    // Not-taken branch
    prog = '{itype(OP_BNEQZ, 0, 0, 16'd2), itype(OP_ADDI, 5, 0, 16'd1),
             itype(OP_ADDI, 6, 0, 16'd1), itype(OP_ADDI, 7, 0, 16'd9), {OP_HLT, 26'b0}};
    exp_rf(5, 1); exp_rf(6, 1); exp_rf(7, 9);
    run("p5");
    chk("p5_r5", dut.regfile[5], 32'd1);
    chk("p5_r6", dut.regfile[6], 32'd1);
    chk("p5_taken_cnt", taken_cnt, 32'd0);

    // Instructions younger than HLT have no effect
    prog = '{{OP_HLT, 26'b0}, itype(OP_ADDI, 8, 0, 16'd5)};
    run("p6");
    chk("p6_r8", dut.regfile[8], 32'd0);
    chk("p6_pc_frozen", 32'(dut.pc), 32'd4);

    // Signed compare, r0 write discard, MUL gating
    prog = '{itype(OP_ADDI, 1, 0, 16'hFFFF), rtype(OP_SLT, 2, 1, 0),
             itype(OP_ADDI, 0, 0, 16'd5), itype(OP_ADDI, 3, 0, 16'd77),
             rtype(OP_MUL, 3, 1, 1), {OP_HLT, 26'b0}};
    exp_rf(1, 32'hFFFFFFFF); exp_rf(2, 1); exp_rf(3, 77);
`ifdef MIPS32_MUL_EN
    exp_rf(3, 1);
`endif
    run("p7");
    chk("p7_r2", dut.regfile[2], 32'd1);
    chk("p7_r0", dut.regfile[0], 32'd0);
`ifdef MIPS32_MUL_EN
    chk("p7_r3", dut.regfile[3], 32'd1);
`else
    chk("p7_r3", dut.regfile[3], 32'd77);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
